alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// Writeback stage: retires ALU results to the register file and flag register,
// and sequences single outstanding LD/ST memory accesses.
module alu_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_out,
    input  logic [1:0]  alu_flags,
    input  logic [31:0] store_data,
    input  logic [31:0] rd_old,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  flags_q
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MEM_RD = 2'd1;
    localparam logic [1:0] MEM_WR = 2'd2;

    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_ADDI  = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_SUBI  = 5'b00101;
    localparam logic [4:0] OP_MUL   = 5'b00110;
    localparam logic [4:0] OP_MOVEH = 5'b00111;
    localparam logic [4:0] OP_DIV   = 5'b01000;
    localparam logic [4:0] OP_AND   = 5'b01010;
    localparam logic [4:0] OP_ANDI  = 5'b01011;
    localparam logic [4:0] OP_OR    = 5'b01100;
    localparam logic [4:0] OP_ORI   = 5'b01101;
    localparam logic [4:0] OP_NOT   = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b10000;
    localparam logic [4:0] OP_XORI  = 5'b10001;
    localparam logic [4:0] OP_CMP   = 5'b10010;
    localparam logic [4:0] OP_ST    = 5'b11100;
    localparam logic [4:0] OP_LD    = 5'b11101;
    localparam logic [4:0] OP_MOVEL = 5'b11110;

    logic [1:0] state;
    logic [4:0] ld_rd;

    assign in_ready = (state == IDLE);

    // rf_we defaults low each cycle so every register write is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ld_rd     <= 5'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
            flags_q   <= 2'b00;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        case (opcode)
                            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_DIV,
                            OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_NOT, OP_XOR,
                            OP_XORI: begin
                                rf_we    <= 1'b1;
                                rf_waddr <= rd;
                                rf_wdata <= alu_out;
                                flags_q  <= alu_flags;
                            end
                            OP_CMP: flags_q <= alu_flags;
                            OP_MOVEL: begin
                                rf_we    <= 1'b1;
                                rf_waddr <= rd;
                                rf_wdata <= {rd_old[31:16], alu_out[15:0]};
                            end
                            OP_MOVEH: begin
                                rf_we    <= 1'b1;
                                rf_waddr <= rd;
                                rf_wdata <= {alu_out[31:16], rd_old[15:0]};
                            end
                            OP_LD: begin
                                state    <= MEM_RD;
                                ld_rd    <= rd;
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= alu_out;
                            end
                            OP_ST: begin
                                state     <= MEM_WR;
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= alu_out;
                                mem_wdata <= store_data;
                            end
                            default: ;
                        endcase
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        rf_we    <= 1'b1;
                        rf_waddr <= ld_rd;
                        rf_wdata <= mem_rdata;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
